// File: rtl/exec_hazard_ctrl.sv
// Execute-stage hazard controller: operand forwarding, load-use stalls, branch flushes
// and stall sequencing for multi-cycle Exec operations, plus a saturating stall counter.
module exec_hazard_ctrl #(
    parameter int MUL_LAT = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  RA1D,
    input  logic [3:0]  RA2D,
    input  logic [3:0]  RA1E,
    input  logic [3:0]  RA2E,
    input  logic [3:0]  WA3E,
    input  logic [3:0]  WA3M,
    input  logic [3:0]  WA3W,
    input  logic        RegWriteE,
    input  logic        RegWriteM,
    input  logic        RegWriteW,
    input  logic        MemtoRegE,
    input  logic        MultiCycleE,
    input  logic        BranchTakenE,
    output logic [1:0]  ForwardAE,
    output logic [1:0]  ForwardBE,
    output logic        StallF,
    output logic        StallD,
    output logic        StallE,
    output logic        FlushD,
    output logic        FlushE,
    output logic        FlushM,
    output logic        ExecBusy,
    output logic [15:0] StallCount
);

    // One-hot encoding leaves illegal codes that the next-state logic recovers from.
    typedef enum logic [1:0] {
        IDLE = 2'b01,
        BUSY = 2'b10
    } state_t;

    localparam logic [3:0] CNT_INIT = 4'(MUL_LAT - 2);

    state_t     state, state_next;
    logic [3:0] cnt, cnt_next;
    logic       busy_stall;
    logic       ld_stall;

    // Register 15 is the PC and never forwards; M is newer than W so it wins.
    always_comb begin
        ForwardAE = 2'b00;
        if (RegWriteM && (WA3M == RA1E) && (RA1E != 4'hF))
            ForwardAE = 2'b10;
        else if (RegWriteW && (WA3W == RA1E) && (RA1E != 4'hF))
            ForwardAE = 2'b01;
    end

    always_comb begin
        ForwardBE = 2'b00;
        if (RegWriteM && (WA3M == RA2E) && (RA2E != 4'hF))
            ForwardBE = 2'b10;
        else if (RegWriteW && (WA3W == RA2E) && (RA2E != 4'hF))
            ForwardBE = 2'b01;
    end

    assign ld_stall = MemtoRegE & RegWriteE & ((RA1D == WA3E) | (RA2D == WA3E));

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // The cycle with cnt==0 in BUSY is the release cycle: no stall, result moves to M.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        busy_stall = 1'b0;
        case (state)
            IDLE: begin
                if (MultiCycleE) begin
                    busy_stall = 1'b1;
                    state_next = BUSY;
                    cnt_next   = CNT_INIT;
                end
            end
            BUSY: begin
                if (cnt == 4'd0) begin
                    state_next = IDLE;
                end else begin
                    busy_stall = 1'b1;
                    cnt_next   = cnt - 4'd1;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = 4'd0;
            end
        endcase
        if (BranchTakenE) begin
            state_next = IDLE;
            cnt_next   = 4'd0;
            busy_stall = 1'b0;
        end
    end

    assign StallE   = busy_stall;
    assign ExecBusy = busy_stall;
    assign FlushM   = busy_stall;
    assign StallF   = (ld_stall | busy_stall) & ~BranchTakenE;
    assign StallD   = (ld_stall | busy_stall) & ~BranchTakenE;
    assign FlushE   = (ld_stall & ~busy_stall) | BranchTakenE;
    assign FlushD   = BranchTakenE;

    always_ff @(posedge clk) begin
        if (reset)
            StallCount <= 16'd0;
        else if (StallF && (StallCount != 16'hFFFF))
            StallCount <= StallCount + 16'd1;
    end

endmodule
